// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the memory-slave initiator.
package mem_pkg;

    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_REQ   = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_master.sv
// Burst initiator for the valid/ready single-port memory slave.
// Takes one command (read/write, base address, beat count) and runs one beat per
// slave handshake at incrementing, wrapping addresses.
//
// Handshake rules: a command or write word transfers on the rising edge where both
// its valid and ready are high. The memory side is four-phase: mem_valid_o stays high
// until the slave's ready is seen, then drops. The master then waits in GAP for ready
// to fall, which absorbs the slave's stale ready and its harmless repeat of the op.
// rd_valid_o has no backpressure.
module mem_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH:0]   cmd_len_i,
    input  logic                  wd_valid_i,
    output logic                  wd_ready_o,
    input  logic [WIDTH-1:0]      wd_data_i,
    output logic                  rd_valid_o,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_rd_en_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  wd_ready_q;
    logic                  rd_valid_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic                  done_q;
    logic                  err_q;
    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wr_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         beat_q;
    logic [TW-1:0]         tmo_q;

    // Next beat address, wrapping at the top of the slave's address space.
    always_comb begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            addr_d = '0;
        end
    end

    // Burst FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            wd_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        wr_q   <= cmd_wr_i;
                        addr_q <= cmd_addr_i;
                        len_q  <= cmd_len_i;
                        beat_q <= '0;
                        tmo_q  <= '0;
                        if (cmd_len_i == '0) begin
                            // Empty burst: acknowledge and stay ready.
                            done_q <= 1'b1;
                        end else if (cmd_wr_i) begin
                            cmd_ready_q <= 1'b0;
                            wd_ready_q  <= 1'b1;
                            state_q     <= ST_FETCH;
                        end else begin
                            cmd_ready_q <= 1'b0;
                            mem_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_FETCH: begin
                    if (wd_valid_i) begin
                        wdata_q     <= wd_data_i;
                        wd_ready_q  <= 1'b0;
                        mem_valid_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ready_i) begin
                        if (!wr_q) begin
                            rd_data_q  <= mem_rdata_i;
                            rd_valid_q <= 1'b1;
                        end
                        mem_valid_q <= 1'b0;
                        addr_q      <= addr_d;
                        beat_q      <= beat_q + LW'(1);
                        state_q     <= ST_GAP;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        // Slave never answered: abort the whole burst.
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (!mem_ready_i) begin
                        if (beat_q == len_q) begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else if (wr_q) begin
                            wd_ready_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end else begin
                            mem_valid_q <= 1'b1;
                            tmo_q       <= '0;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign wd_ready_o     = wd_ready_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign mem_valid_o    = mem_valid_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_wr_rd_en_o = wr_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master paired with a behavioural model of the memory slave.
module tb_mem_master;
  import mem_pkg::*;

  localparam int W  = 16;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          wd_valid, wd_ready;
  logic [W-1:0]  wd_data;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          done, err;
  logic          mem_valid, mem_wr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  mem_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .done_o(done), .err_o(err),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wr_rd_en_o(mem_wr), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  // ---------------- memory slave model ----------------
  // Ready follows valid by one cycle (so it is stale for one cycle after valid drops),
  // the op repeats while valid is held, and reset is synchronous.
  logic [W-1:0] mem [D];
  logic         s_ready;
  logic [W-1:0] s_rdata;
  logic         stall_ready;
  logic         mem_clr;

  always @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b0;
      s_rdata <= '0;
      if (mem_clr) begin
        for (int i = 0; i < D; i++) mem[i] <= '0;
      end
    end else begin
      s_ready <= mem_valid;
      if (mem_valid) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        s_rdata <= mem[mem_addr];
      end
    end
  end

  assign mem_ready = s_ready & ~stall_ready;
  assign mem_rdata = s_rdata;

  // ---------------- scoreboard / monitor ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rd_cnt = 0;
  int mv_rises = 0, mv_high = 0;
  int rise_t[$];
  logic mv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
    if (mem_valid) mv_high <= mv_high + 1;
    if (mem_valid && !mv_prev) begin
      mv_rises <= mv_rises + 1;
      rise_t.push_back(cyc);
    end
    mv_prev <= mem_valid;
    if (rd_valid) begin
      rd_cnt <= rd_cnt + 1;
      check("rd_expected_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW:0] len);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [AW:0] len,
                             input logic [W-1:0] base, input int stall_beat);
    int n;
    int mv_bad;
    issue_cmd(1'b1, addr, len);
    for (int b = 0; b < int'(len); b++) begin
      n = 0;
      while (!wd_ready && n < 50) begin
        tick();
        n++;
      end
      check("wd_ready_seen", 32'(wd_ready), 32'd1);
      if (b == stall_beat) begin
        mv_bad = 0;
        for (int s = 0; s < 10; s++) begin
          tick();
          if (mem_valid) mv_bad++;
        end
        check("stall_mem_valid_low", 32'(mv_bad), 32'd0);
      end
      wd_valid = 1'b1;
      wd_data  = base + W'(b);
      tick();
      wd_valid = 1'b0;
      wd_data  = '0;
    end
    wait_done("write_done", 40);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rc0, r0, h0, b0, d0, e0, n;
    rst = 1'b1; mem_clr = 1'b1; stall_ready = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    tick(); tick();

    // 1: reset values, then an empty burst
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_misc", {22'd0, wd_ready, rd_valid, done, err, mem_valid, mem_wr, 4'd0}, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    tick();
    issue_cmd(1'b0, 6'h05, 7'd0);
    check("len0_done_pulse", 32'(done), 32'd1);
    tick();
    check("len0_done_once", 32'(done), 32'd0);
    check("len0_no_mem_valid", 32'(mv_rises), 32'd0);
    check("len0_still_ready", 32'(cmd_ready), 32'd1);

    // 2: wrapping write burst
    e0 = err_cnt;
    write_burst(6'h3E, 7'd4, 16'hA001, -1);
    check("wr_mem_3e", 32'(mem[6'h3E]), 32'hA001);
    check("wr_mem_3f", 32'(mem[6'h3F]), 32'hA002);
    check("wr_mem_00", 32'(mem[6'h00]), 32'hA003);
    check("wr_mem_01", 32'(mem[6'h01]), 32'hA004);
    check("wr_mem_02_untouched", 32'(mem[6'h02]), 32'h0000);
    check("wr_no_err", 32'(err_cnt - e0), 32'd0);
    tick();
    check("wr_single_done", 32'(done), 32'd0);

    // 3: wrapping read burst, beat period
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA002);
    exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
    rc0 = rd_cnt;
    r0  = rise_t.size();
    issue_cmd(1'b0, 6'h3E, 7'd4);
    wait_done("rd_done", 60);
    check("rd_beats", 32'(rd_cnt - rc0), 32'd4);
    check("rd_all_consumed", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) check("rd_beat_period", 32'(rise_t[r0+i+1] - rise_t[r0+i]), 32'd4);
    tick();

    // 4: write with a 10-cycle data stall before beat 2
    write_burst(6'h10, 7'd3, 16'hB001, 1);
    check("stall_mem_10", 32'(mem[6'h10]), 32'hB001);
    check("stall_mem_11", 32'(mem[6'h11]), 32'hB002);
    check("stall_mem_12", 32'(mem[6'h12]), 32'hB003);
    tick();

    // 5: slave never answers -> timeout abort
    stall_ready = 1'b1;
    h0 = mv_high; b0 = both_cnt; rc0 = rd_cnt;
    issue_cmd(1'b0, 6'h05, 7'd2);
    wait_done("tmo_done", 40);
    check("tmo_valid_cycles", 32'(mv_high - h0), 32'd16);
    check("tmo_done_err_together", 32'(both_cnt - b0), 32'd1);
    check("tmo_no_rd", 32'(rd_cnt - rc0), 32'd0);
    check("tmo_valid_dropped", 32'(mem_valid), 32'd0);
    check("tmo_back_idle", 32'(cmd_ready), 32'd1);
    stall_ready = 1'b0;
    tick(); tick(); tick();

    // 6: async reset mid-read, then a fresh burst
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA002);
    exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
    rc0 = rd_cnt;
    issue_cmd(1'b0, 6'h3E, 7'd4);
    n = 0;
    while ((rd_cnt - rc0) < 2 && n < 40) begin
      tick();
      n++;
    end
    check("rst6_two_beats", 32'(rd_cnt - rc0), 32'd2);
    check("rst6_busy", 32'(cmd_ready), 32'd0);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    check("rst6_async_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst6_async_rd_data", 32'(rd_data), 32'd0);
    check("rst6_async_mem_valid", 32'(mem_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("rst6_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
    rc0 = rd_cnt;
    issue_cmd(1'b0, 6'h00, 7'd2);
    wait_done("rst6_new_done", 40);
    check("rst6_new_beats", 32'(rd_cnt - rc0), 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
